// File: rtl/vga_fetch_if.sv
// SRAM read-port bundle between the frame-buffer fetcher and the ZBT SRAM.
// master: fetcher (drives strobe/address), slave: SRAM (returns data 2 cycles later).
interface vga_fetch_if #(
   parameter int LOG_MEM  = 36,
   parameter int LOG_ADDR = 19
) ();
   logic                mem_re;
   logic [LOG_ADDR-1:0] mem_addr;
   logic [LOG_MEM-1:0]  mem_rdata;

   modport master (output mem_re, output mem_addr, input  mem_rdata);
   modport slave  (input  mem_re, input  mem_addr, output mem_rdata);
endinterface

// File: rtl/vga_fetch.sv
// Frame-buffer read port for the VGA output stage.
// Each accepted vga_flag request issues one ZBT read of a 36-bit word (two
// YCbCr pixels); the word comes back on vga_pixel two cycles later. The block
// walks a linear offset through the displayed buffer, ping-pongs between two
// buffers at frame boundaries and pulses done_vga once a whole frame is out.
module vga_fetch #(
   parameter int LOG_MEM        = 36,
   parameter int LOG_ADDR       = 19,
   parameter int WORDS_PER_LINE = 320,
   parameter int LINES          = 480,
   parameter int BUF0_BASE      = 0,
   parameter int BUF1_BASE      = 153600
) (
   input  logic               clock,
   input  logic               reset_b,
   input  logic               frame_flag,
   input  logic               frame_ready,
   input  logic               vga_flag,
   output logic [LOG_MEM-1:0] vga_pixel,
   output logic               done_vga,
   output logic               display_buf,
   output logic               overrun,
   vga_fetch_if.master        mem
);

   localparam int OFS_W = 18;
   // Offset of the last word of a frame; a constant, so no multiplier is built.
   localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(WORDS_PER_LINE * LINES - 1);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] STREAMING = 2'd1;
   localparam logic [1:0] DRAINING  = 2'd2;
   localparam logic [1:0] DONE      = 2'd3;

   logic [1:0]          state;
   logic [OFS_W-1:0]    offset;
   logic                swap_pending;
   logic [1:0]          valid_pipe;   // [0]: read issued last cycle, [1]: data arriving now
   logic [LOG_MEM-1:0]  hold;
   logic                accept;
   logic [LOG_ADDR-1:0] base;

   // A request is taken only while streaming, outside a frame boundary and
   // with no read still in flight (the SRAM port serves one word per 3 cycles).
   assign accept = vga_flag && reset_b && !frame_flag &&
                   (state == STREAMING) && (valid_pipe == 2'b00);

   assign base         = display_buf ? LOG_ADDR'(BUF1_BASE) : LOG_ADDR'(BUF0_BASE);
   assign mem.mem_re   = accept;
   assign mem.mem_addr = reset_b ? (base + LOG_ADDR'(offset)) : LOG_ADDR'(BUF0_BASE);

   // Data is bypassed straight from the SRAM in its arrival cycle, then held.
   assign vga_pixel = valid_pipe[1] ? mem.mem_rdata : hold;

   // Frame sequencing: state, scan offset and the end-of-frame pulse.
   always_ff @(posedge clock) begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!reset_b) begin
         state    <= IDLE;
         offset   <= '0;
         done_vga <= 1'b0;
      end else begin
         done_vga <= 1'b0;
         if (frame_flag) begin
            // Frame boundary wins over everything, including a pending drain.
            state  <= STREAMING;
            offset <= '0;
         end else begin
            if (accept)
               offset <= (offset == LAST_OFS) ? '0 : offset + 1'b1;
            case (state)
               STREAMING: if (accept && offset == LAST_OFS) state <= DRAINING;
               DRAINING: begin
                  if (valid_pipe[1]) begin
                     done_vga <= 1'b1;
                     state    <= DONE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Double-buffer bookkeeping: swap only at a frame boundary after the writer
   // has finished the back buffer; a coincident frame_ready counts for the next frame.
   always_ff @(posedge clock) begin
      if (!reset_b) begin
         display_buf  <= 1'b0;
         swap_pending <= 1'b0;
      end else begin
         if (frame_flag && swap_pending)
            display_buf <= ~display_buf;
         if (frame_ready)
            swap_pending <= 1'b1;
         else if (frame_flag)
            swap_pending <= 1'b0;
      end
   end

   // Read-return tracking and capture of the returned word.
   always_ff @(posedge clock) begin
      // NOTE: the hold register is datapath, but it is reset because it is
      // directly visible on vga_pixel and must read 0 after reset.
      if (!reset_b) begin
         valid_pipe <= 2'b00;
         hold       <= '0;
      end else begin
         valid_pipe <= {valid_pipe[0], accept};
         if (valid_pipe[1])
            hold <= mem.mem_rdata;
      end
   end

   // Sticky error: any request that could not be served.
   always_ff @(posedge clock) begin
      if (!reset_b)
         overrun <= 1'b0;
      else if (vga_flag && !accept)
         overrun <= 1'b1;
   end

endmodule
